delay_line_meas: RTL

- Measurement stage directly downstream of the tapped delay line.
- Launches an edge into the line and captures the thermometer-coded tap vector one clock later.
- Converts the captured taps to a tap count, averages over 2^AVG_LOG2 launches, and presents the result on a valid/ready interface to the readout logic.

---
 rtl/delay_line_meas.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/delay_line_meas.sv
// Tapped delay line measurement stage: launches an edge, captures the thermometer-coded
// taps, averages 2^AVG_LOG2 tap counts. Optional min/max tracking: DELAY_LINE_MEAS_MINMAX_EN.
module delay_line_meas #(
  parameter int TAPS        = 64,
  parameter int CW          = $clog2(TAPS + 1),
  parameter int AVG_LOG2    = 2,
  parameter int RECOVER_CYC = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  output logic            o_launch,
  input  logic [TAPS-1:0] i_taps,
  output logic            o_busy,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [CW-1:0]   o_count,
  output logic            o_bubble
`ifdef DELAY_LINE_MEAS_MINMAX_EN
  ,
  output logic [CW-1:0]   o_min,
  output logic [CW-1:0]   o_max
`endif
);

  localparam int AW   = CW + AVG_LOG2;
  localparam int SW   = AVG_LOG2 + 1;
  localparam int RW   = (RECOVER_CYC > 0) ? $clog2(RECOVER_CYC + 1) : 1;
  localparam int NSMP = 1 << AVG_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_SAMPLE, S_RECOVER, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [TAPS-1:0] tap_q;
  logic [AW-1:0]   acc_q, acc_d, acc_sum;
  logic [SW-1:0]   smp_q, smp_d;
  logic [RW-1:0]   rc_q, rc_d;
  logic            bub_q, bub_d;
  logic [CW-1:0]   count_q, count_d;
  logic            obub_q, obub_d;
  logic            launch_q, launch_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_v;
  logic            bub_v;
  logic            zero_seen;
`ifdef DELAY_LINE_MEAS_MINMAX_EN
  logic [CW-1:0]   min_q, min_d, max_q, max_d;
  logic [CW-1:0]   omin_q, omin_d, omax_q, omax_d;
  logic [CW-1:0]   min_upd, max_upd;
`endif

  // Ones run from bit 0; any 1 after the first 0 is a thermometer bubble.
  always_comb begin
    cnt_v     = '0;
    bub_v     = 1'b0;
    zero_seen = 1'b0;
    for (int unsigned i = 0; i < TAPS; i++) begin
      if (tap_q[i]) begin
        if (zero_seen) bub_v = 1'b1;
        else           cnt_v = cnt_v + CW'(1);
      end else begin
        zero_seen = 1'b1;
      end
    end
  end

  assign acc_sum = acc_q + AW'(cnt_v);
`ifdef DELAY_LINE_MEAS_MINMAX_EN
  assign min_upd = (cnt_v < min_q) ? cnt_v : min_q;
  assign max_upd = (cnt_v > max_q) ? cnt_v : max_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    smp_d   = smp_q;
    rc_d    = rc_q;
    bub_d   = bub_q;
    count_d = count_q;
    obub_d  = obub_q;
`ifdef DELAY_LINE_MEAS_MINMAX_EN
    min_d   = min_q;
    max_d   = max_q;
    omin_d  = omin_q;
    omax_d  = omax_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LAUNCH;
          acc_d   = '0;
          smp_d   = '0;
          bub_d   = 1'b0;
`ifdef DELAY_LINE_MEAS_MINMAX_EN
          min_d   = CW'(TAPS);
          max_d   = '0;
`endif
        end
      end
      S_LAUNCH: state_d = S_SAMPLE;
      S_SAMPLE: begin
        acc_d = acc_sum;
        bub_d = bub_q | bub_v;
        smp_d = smp_q + SW'(1);
`ifdef DELAY_LINE_MEAS_MINMAX_EN
        min_d = min_upd;
        max_d = max_upd;
`endif
        rc_d  = '0;
        if (smp_q == SW'(NSMP - 1)) begin
          state_d = S_DONE;
          count_d = CW'(acc_sum >> AVG_LOG2);
          obub_d  = bub_q | bub_v;
`ifdef DELAY_LINE_MEAS_MINMAX_EN
          omin_d  = min_upd;
          omax_d  = max_upd;
`endif
        end else if (RECOVER_CYC == 0) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        rc_d = rc_q + RW'(1);
        if (rc_q == RW'(RECOVER_CYC - 1)) state_d = S_LAUNCH;
      end
      S_DONE: begin
        if (i_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output flags are registered copies of the next state's decode.
  assign launch_d = (state_d == S_LAUNCH);
  assign valid_d  = (state_d == S_DONE);
  assign busy_d   = (state_d != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tap_q    <= '0;
      acc_q    <= '0;
      smp_q    <= '0;
      rc_q     <= '0;
      bub_q    <= 1'b0;
      count_q  <= '0;
      obub_q   <= 1'b0;
      launch_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DELAY_LINE_MEAS_MINMAX_EN
      min_q    <= '0;
      max_q    <= '0;
      omin_q   <= '0;
      omax_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      tap_q    <= i_taps;
      acc_q    <= acc_d;
      smp_q    <= smp_d;
      rc_q     <= rc_d;
      bub_q    <= bub_d;
      count_q  <= count_d;
      obub_q   <= obub_d;
      launch_q <= launch_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef DELAY_LINE_MEAS_MINMAX_EN
      min_q    <= min_d;
      max_q    <= max_d;
      omin_q   <= omin_d;
      omax_q   <= omax_d;
`endif
    end
  end

  assign o_launch = launch_q;
  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_count  = count_q;
  assign o_bubble = obub_q;
`ifdef DELAY_LINE_MEAS_MINMAX_EN
  assign o_min    = omin_q;
  assign o_max    = omax_q;
`endif

endmodule
